// File: rtl/rr_arb16_pkg.sv
// rr_arb16_pkg: shared constants, FSM state encoding and one-hot decode for the 16-way arbiter
package rr_arb16_pkg;
    localparam int NREQ = 16;
    localparam int IDW  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01,
        GAP   = 2'b10
    } state_t;

    function automatic logic [NREQ-1:0] onehot16(input logic [IDW-1:0] id);
        return NREQ'(1) << id;
    endfunction
endpackage

// File: rtl/rr_arb16_pri_enc16.sv
// pri_enc16: combinational lowest-set-bit encoder
//   vec : 16-bit input vector
//   idx : index of the lowest set bit (0 when vec is zero)
//   any : high when any bit of vec is set
module pri_enc16
    import rr_arb16_pkg::*;
(
    input  logic [NREQ-1:0] vec,
    output logic [IDW-1:0]  idx,
    output logic            any
);
    always_comb begin
        idx = '0;
        for (int i = NREQ - 1; i >= 0; i--)
            if (vec[i]) idx = IDW'(i);
    end

    assign any = |vec;
endmodule

// File: rtl/rr_arb16.sv
// rr_arb16: 16-way round-robin arbiter with registered one-hot grant and one dead cycle between owners
//   TMAX  : maximum grant tenure in cycles (only used with RR_TIMEOUT_EN)
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   req   : level-sensitive request vector
//   done  : single-cycle release pulse from the current owner
//   gnt   : registered one-hot grant, zero when idle
//   gid   : registered index of the granted requester, held while gv=0
//   gv    : grant valid (OR of gnt)
//   tout  : one-cycle pulse when a grant is revoked by timeout
// Optional feature: define RR_TIMEOUT_EN to build the tenure counter and forced release.
module rr_arb16
    import rr_arb16_pkg::*;
#(
    parameter int unsigned TMAX = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            done,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gid,
    output logic            gv,
    output logic            tout
);
    if (TMAX < 1 || TMAX > 65535) begin : g_tmax_chk
        $error("rr_arb16: TMAX out of range");
    end

    state_t          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [IDW-1:0]  gid_q, gid_d;
    logic            gv_q, gv_d;
    logic [IDW-1:0]  p_q, p_d;
    logic [NREQ-1:0] h;
    logic [IDW-1:0]  h_idx, r_idx, win;
    logic            h_any, req_any, take, to;

    // Upper set: requests strictly above the last winner; empty when p=15.
    assign h = req & (16'hFFFE << p_q);

    pri_enc16 u_hi  (.vec(h),   .idx(h_idx), .any(h_any));
    pri_enc16 u_all (.vec(req), .idx(r_idx), .any(req_any));

    assign win = h_any ? h_idx : r_idx;

`ifdef RR_TIMEOUT_EN
    localparam int CW = $clog2(TMAX + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tout_q, tout_d;
    assign to   = (state_q == GRANT) && (cnt_q == CW'(TMAX - 1));
    assign tout = tout_q;
`else
    assign to   = 1'b0;
    assign tout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        gid_d   = gid_q;
        gv_d    = gv_q;
        p_d     = p_q;
        take    = 1'b0;
`ifdef RR_TIMEOUT_EN
        cnt_d   = (state_q == GRANT) ? cnt_q + CW'(1) : cnt_q;
        tout_d  = 1'b0;
`endif
        unique case (state_q)
            IDLE: take = req_any;
            GRANT: begin
                if (done || !req[gid_q] || to) begin
                    state_d = GAP;
                    gnt_d   = '0;
                    gv_d    = 1'b0;
`ifdef RR_TIMEOUT_EN
                    tout_d  = to;
`endif
                end
            end
            GAP: begin
                state_d = IDLE;
                take    = req_any;
            end
            default: state_d = IDLE;
        endcase
        // Pointer moves only on a new grant, so a timed-out owner falls to lowest priority.
        if (take) begin
            state_d = GRANT;
            gnt_d   = onehot16(win);
            gid_d   = win;
            gv_d    = 1'b1;
            p_d     = win;
`ifdef RR_TIMEOUT_EN
            cnt_d   = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            gid_q   <= '0;
            gv_q    <= 1'b0;
            p_q     <= IDW'(NREQ - 1);
`ifdef RR_TIMEOUT_EN
            cnt_q   <= '0;
            tout_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            gid_q   <= gid_d;
            gv_q    <= gv_d;
            p_q     <= p_d;
`ifdef RR_TIMEOUT_EN
            cnt_q   <= cnt_d;
            tout_q  <= tout_d;
`endif
        end
    end

    assign gnt = gnt_q;
    assign gid = gid_q;
    assign gv  = gv_q;
endmodule

// File: tb/tb_rr_arb16.sv
// tb_rr_arb16: directed self-checking bench for rr_arb16
module tb_rr_arb16;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] req = '0;
    logic        done = 1'b0;
    logic [15:0] gnt;
    logic [3:0]  gid;
    logic        gv;
    logic        tout;
    int          checks = 0;
    int          errors = 0;

    rr_arb16 #(.TMAX(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .gnt(gnt), .gid(gid), .gv(gv), .tout(tout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        done  = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        #3;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_gid", 32'(gid), 32'h0);
        chk("rst_gv", 32'(gv), 32'h0);
        chk("rst_tout", 32'(tout), 32'h0);
        do_reset();

        req = 16'h0001;
        step();
        chk("t1_gnt", 32'(gnt), 32'h0001);
        chk("t1_gid", 32'(gid), 32'h0);
        chk("t1_gv", 32'(gv), 32'h1);
        done = 1'b1;
        step();
        chk("t1_gap_gnt", 32'(gnt), 32'h0);
        chk("t1_gap_gv", 32'(gv), 32'h0);
        chk("t1_gap_gid", 32'(gid), 32'h0);
        done = 1'b0;
        req  = '0;
        step();
        chk("t1_idle_gnt", 32'(gnt), 32'h0);
        step();
        chk("t1_idle_gv", 32'(gv), 32'h0);

        do_reset();
        req  = 16'hFFFF;
        done = 1'b1;
        for (int k = 0; k < 17; k++) begin
            step();
            chk("rot_gid", 32'(gid), 32'(k % 16));
            chk("rot_gnt", 32'(gnt), 32'h1 << (k % 16));
            step();
            chk("rot_gap", 32'(gv), 32'h0);
        end
        req = '0;
        step();

        do_reset();
        req  = 16'h0020;
        done = 1'b0;
        step();
        chk("p5_gid", 32'(gid), 32'h5);
        done = 1'b1;
        step();
        done = 1'b0;
        req  = 16'h0021;
        step();
        chk("p5_win0", 32'(gid), 32'h0);
        chk("p5_win0_gnt", 32'(gnt), 32'h0001);
        done = 1'b1;
        step();
        done = 1'b0;
        step();
        chk("p0_win5", 32'(gid), 32'h5);
        chk("p0_win5_gnt", 32'(gnt), 32'h0020);

        req  = '0;
        done = 1'b1;
        step();
        done = 1'b0;
        step();
        chk("idle_before_t4", 32'(gv), 32'h0);
        req = 16'h0008;
        step();
        chk("t4_gid", 32'(gid), 32'h3);
        step();
        step();
        chk("t4_hold_gid", 32'(gid), 32'h3);
        chk("t4_hold_gv", 32'(gv), 32'h1);
        req = '0;
        step();
        chk("t4_drop_gap", 32'(gv), 32'h0);
        chk("t4_drop_gid", 32'(gid), 32'h3);
        step();
        chk("t4_idle", 32'(gv), 32'h0);
        req = 16'h0008;
        step();
        chk("t4_regrant", 32'(gnt), 32'h0008);
        req  = '0;
        done = 1'b1;
        step();
        chk("t4_both_gap", 32'(gv), 32'h0);
        done = 1'b0;
        req  = 16'h0008;
        step();
        chk("t4_single_gap", 32'(gnt), 32'h0008);

        do_reset();
        req = 16'h0006;
        step();
        chk("to_gid", 32'(gid), 32'h1);
`ifdef RR_TIMEOUT_EN
        for (int k = 0; k < 3; k++) begin
            step();
            chk("to_hold", 32'({gv, gid}), 32'h11);
            chk("to_tout_lo", 32'(tout), 32'h0);
        end
        step();
        chk("to_gap_gv", 32'(gv), 32'h0);
        chk("to_tout", 32'(tout), 32'h1);
        step();
        chk("to_next_gid", 32'(gid), 32'h2);
        chk("to_tout_end", 32'(tout), 32'h0);
`else
        for (int k = 0; k < 6; k++) begin
            step();
            chk("noto_hold", 32'({gv, gid}), 32'h11);
            chk("noto_tout", 32'(tout), 32'h0);
        end
`endif

        do_reset();
        req = 16'h0008;
        step();
        chk("mr_pre_gid", 32'(gid), 32'h3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_gnt", 32'(gnt), 32'h0);
        chk("mr_gv", 32'(gv), 32'h0);
        chk("mr_gid", 32'(gid), 32'h0);
        step();
        rst_n = 1'b1;
        req   = 16'h8001;
        step();
        chk("mr_after_gid", 32'(gid), 32'h0);
        chk("mr_after_gnt", 32'(gnt), 32'h0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rr_arb16.md
# rr_arb16

Sixteen-way round-robin arbiter that shares a single datapath resource (bus port, multiplier, memory bank) among 16 requesters. It samples a request vector, grants exactly one requester at a time with a registered one-hot grant plus its binary index, holds the grant until the owner releases, then inserts one dead cycle before re-arbitrating. It sits between the requester ports and the shared resource's select/mux logic; the mux is driven directly from `gid`.

## Interface

- `TMAX`, 255: maximum grant tenure in cycles (1..65535). Used only when the timeout feature is compiled in.
- `clk` input 1: clock; all state changes on its rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `req` input 16: request vector; bit i high means requester i wants the resource. Level-sensitive.
- `done` input 1: single-cycle release pulse from the current owner.
- `gnt` output 16: registered one-hot grant; all zero when idle.
- `gid` output 4: registered index of the granted requester; holds its last value when `gv`=0.
- `gv` output 1: grant valid; equals OR of `gnt`.
- `tout` output 1: one-cycle pulse when a grant is revoked by timeout; tied 0 when the feature is compiled out.

## Operation

- Reset values: `gnt`=0, `gid`=0, `gv`=0, `tout`=0, state IDLE, pointer `p`=15 (requester 0 has first priority after reset), tenure counter 0.
- States:
  - IDLE: if `req`≠0, pick the winner and go to GRANT; otherwise stay.
  - GRANT: `gnt`, `gid`, `gv` held constant. Go to GAP when `done`=1, when `req[gid]`=0, or on timeout.
  - GAP: `gnt`=0, `gv`=0 for exactly one cycle. If `req`≠0, pick the winner and go to GRANT; otherwise go to IDLE.
- Winner selection, combinational from `req` and `p`:
  - Upper set H = `req` with bits 0..p cleared.
  - If H≠0, the winner is the lowest set index in H; otherwise it is the lowest set index in `req`.
  - On entering GRANT, `p` is loaded with the winner index.
  - With p=15, H is always empty, so the lowest set `req` wins.
- A requester that drops `req` while not granted simply loses eligibility; no state is kept per requester.
- `done` is ignored in IDLE and GAP.
- `done` and `req[gid]` falling in the same cycle count as one release.
- Timeout, when the feature is compiled in:
  - The tenure counter clears on GRANT entry and increments every GRANT cycle.
  - When it reaches TMAX-1 without a release, the next cycle is GAP and `tout`=1 for that GAP cycle.
  - `p` is not altered by a timeout, so the revoked owner drops to lowest priority.
- `rst_n` assertion mid-grant immediately clears all outputs, regardless of `clk`.

## Timing

- Request-to-grant latency is one cycle from IDLE: `req` seen high at edge n gives `gnt` valid after edge n+1.
- Release-to-next-grant: `done` sampled at edge n gives `gnt`=0 after edge n+1 (GAP) and the new `gnt` after edge n+2.
- Back-to-back owners therefore see exactly one zero-grant cycle between them.
- Minimum tenure is one cycle: GRANT then immediate release.
- With all 16 requesting continuously, each owner holding one cycle, grants rotate 0,1,…,15,0 at one grant per two cycles.
- `gnt`, `gid`, `gv`, `tout` are all register outputs; there is no combinational path from `req` or `done` to any output.

## Configuration

- `RR_TIMEOUT_EN` defined: the tenure counter (width ceil(log2(TMAX+1))) and the forced-release logic are built, and `tout` pulses as described.
- `RR_TIMEOUT_EN` undefined: no counter is built, a grant is held indefinitely until `done` or the request drop, `tout` is constant 0, and `TMAX` is unused.

## Structure

- The shared package holds:
  - `NREQ`=16 and `IDW`=4.
  - The state enum {IDLE, GRANT, GAP} with encoding 2'b00, 2'b01, 2'b10.
  - A `onehot16(id)` decode function.
- One sub-module, `pri_enc16`: a purely combinational lowest-set-bit encoder (16-bit in, 4-bit index plus `any` out). It is instantiated twice, once for H and once for `req`.
- The upper-set mask ("clear bits 0..p") is generated inline.

## Test plan

- Reset then `req`=16'h0001: `gnt`=16'h0001 and `gid`=0 one cycle later; `done` gives a GAP cycle, then IDLE with `gnt`=0.
- `req`=16'hFFFF held, `done` pulsed every GRANT cycle: `gid` sequence 0,1,2,…,15,0 with `gv` alternating 1,0.
- p=5, `req`=16'h0021 (bits 0 and 5): bit 0 wins. Then with p=0 and `req`=16'h0021, bit 5 wins.
- Owner 3 drops `req[3]` without `done`: GAP follows next cycle, and `done` and the drop together in one cycle produce a single GAP.
- `RR_TIMEOUT_EN`, TMAX=4, `req`=16'h0006 held, no `done`: owner 1 for 4 cycles, then GAP with `tout`=1, then owner 2.
- `rst_n` low mid-grant between clock edges: `gnt`, `gv` and `gid` go to 0 immediately. After release, `req`=16'h8001 grants bit 0.
